// File: rtl/ship_gun.sv
// ship_gun: player-ship controller feeding the laser stage.
//   - two-flop synchronisers and counter debouncers for left/right/fire
//   - once-per-frame horizontal movement clamped to the visible screen
//   - fire FSM (READY/COOLDOWN) producing a single-cycle shot request
//   - registered ship colour for the current beam position
// Optional feature macro: SHIP_AUTOFIRE_EN
//   defined   : a held (debounced) fire level re-fires every cooldown period
//   undefined : only a debounced 0->1 fire edge produces a shot
module ship_gun #(
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int SHIP_WIDTH      = 60,
    parameter int SHIP_HEIGHT     = 30,
    parameter int V_OFFSET        = 10,
    parameter int STEP_MOTION     = 2,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int FIRE_COOLDOWN   = 30,
    parameter int BACKGROUND      = 0,
    parameter int SHIP            = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_btn_fire,
    input  logic       i_laser_active,
    input  logic [9:0] i_h_pos,
    input  logic [9:0] i_v_pos,
    output logic [9:0] o_gun_position,
    output logic       o_fire,
    output logic [2:0] o_color_ship
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int COOL_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    localparam logic [CNT_W-1:0]  DB_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  DB_ONE    = CNT_W'(1);
    // Counter value seen on the last differing sample before acceptance
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [COOL_W-1:0] COOL_ZERO = COOL_W'(0);
    localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(FIRE_COOLDOWN);

    // Movement arithmetic is 11 bits wide so a step below zero cannot wrap
    localparam logic [10:0] HALF_W    = 11'(SHIP_WIDTH / 2);
    localparam logic [10:0] STEP      = 11'(STEP_MOTION);
    localparam logic [10:0] GUN_MIN   = 11'(SHIP_WIDTH / 2);
    localparam logic [10:0] GUN_MAX   = 11'(SCREEN_WIDTH - SHIP_WIDTH / 2);
    localparam logic [9:0]  GUN_RESET = 10'(SCREEN_WIDTH / 2);

    localparam logic [9:0]  TICK_V    = 10'(SCREEN_HEIGHT);
    localparam logic [9:0]  SHIP_Y0   = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT);
    localparam logic [9:0]  SHIP_Y1   = 10'(SCREEN_HEIGHT - V_OFFSET);

    localparam logic [2:0]  COLOR_BG   = 3'(BACKGROUND);
    localparam logic [2:0]  COLOR_SHIP = 3'(SHIP);

    // Button bit positions inside the packed button vectors
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_FIRE  = 2;

    typedef enum logic [0:0] {
        ST_READY    = 1'b0,
        ST_COOLDOWN = 1'b1
    } fire_state_t;

    // ------------------------------------------------------------------
    // Button synchronisation and debouncing
    // ------------------------------------------------------------------
    logic [2:0]       w_btn_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [CNT_W-1:0] r_db_cnt [3];

    assign w_btn_raw = {i_btn_fire, i_btn_right, i_btn_left};

    // Two-flop synchroniser plus per-button stability counter; the debounced
    // level only follows the synchronised input after an unbroken run of
    // DEBOUNCE_CYCLES differing samples. Runs regardless of i_enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_deb   <= 3'b000;
            for (int b = 0; b < 3; b++) begin
                r_db_cnt[b] <= DB_ZERO;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int b = 0; b < 3; b++) begin
                if (r_sync2[b] == r_deb[b]) begin
                    r_db_cnt[b] <= DB_ZERO;
                end else if (r_db_cnt[b] == DB_LAST) begin
                    r_deb[b]    <= r_sync2[b];
                    r_db_cnt[b] <= DB_ZERO;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + DB_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame tick: the beam sits at (0, SCREEN_HEIGHT) exactly once a frame
    // ------------------------------------------------------------------
    logic w_tick;
    logic w_step_en;

    assign w_tick    = (i_h_pos == 10'd0) && (i_v_pos == TICK_V);
    assign w_step_en = w_tick && i_enable;

    // ------------------------------------------------------------------
    // Horizontal movement
    // ------------------------------------------------------------------
    logic [9:0]  r_gun;
    logic [10:0] w_gun_ext;
    logic [10:0] w_gun_next;
    logic        w_go_left;
    logic        w_go_right;

    assign w_gun_ext  = {1'b0, r_gun};
    assign w_go_left  = r_deb[B_LEFT]  && !r_deb[B_RIGHT];
    assign w_go_right = r_deb[B_RIGHT] && !r_deb[B_LEFT];

    // Next ship centre: one step per enabled tick, clamped so the whole ship
    // stays on screen; both buttons or neither hold position.
    always_comb begin
        w_gun_next = w_gun_ext;
        if (w_step_en && w_go_left) begin
            if (w_gun_ext <= (GUN_MIN + STEP)) begin
                w_gun_next = GUN_MIN;
            end else begin
                w_gun_next = w_gun_ext - STEP;
            end
        end else if (w_step_en && w_go_right) begin
            if ((w_gun_ext + STEP) >= GUN_MAX) begin
                w_gun_next = GUN_MAX;
            end else begin
                w_gun_next = w_gun_ext + STEP;
            end
        end else begin
            w_gun_next = w_gun_ext;
        end
    end

    // Ship centre register; starts mid-screen.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gun <= GUN_RESET;
        end else begin
            r_gun <= w_gun_next[9:0];
        end
    end

    // ------------------------------------------------------------------
    // Fire FSM
    // ------------------------------------------------------------------
    fire_state_t       r_state;
    logic [COOL_W-1:0] r_cool;
    logic              r_fire;
    logic              r_deb_fire_d;
    logic              w_fire_edge;
    logic              w_fire_req;

    assign w_fire_edge = r_deb[B_FIRE] && !r_deb_fire_d;

`ifdef SHIP_AUTOFIRE_EN
    // Held button keeps requesting; the cooldown paces the shots.
    assign w_fire_req = r_deb[B_FIRE];
`else
    // Only a fresh press requests a shot; holding the button fires once.
    assign w_fire_req = w_fire_edge;
`endif

    // Shot sequencing: a request in READY with no laser in flight fires a
    // single-cycle pulse and arms the frame-based cooldown. Requests that
    // cannot be served are dropped, never queued.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_READY;
            r_cool       <= COOL_ZERO;
            r_fire       <= 1'b0;
            r_deb_fire_d <= 1'b0;
        end else begin
            r_deb_fire_d <= r_deb[B_FIRE];
            r_fire       <= 1'b0;
            case (r_state)
                ST_READY: begin
                    if (w_fire_req && !i_laser_active && i_enable) begin
                        r_fire  <= 1'b1;
                        r_cool  <= COOL_LOAD;
                        r_state <= ST_COOLDOWN;
                    end else begin
                        r_state <= ST_READY;
                    end
                end
                ST_COOLDOWN: begin
                    if (w_step_en) begin
                        if (r_cool <= COOL_ONE) begin
                            r_cool  <= COOL_ZERO;
                            r_state <= ST_READY;
                        end else begin
                            r_cool  <= r_cool - COOL_ONE;
                        end
                    end else begin
                        r_state <= ST_COOLDOWN;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_cool  <= COOL_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ship colour
    // ------------------------------------------------------------------
    logic [10:0] w_h_ext;
    logic        w_in_x;
    logic        w_in_y;
    logic [2:0]  r_color;

    assign w_h_ext = {1'b0, i_h_pos};
    assign w_in_x  = (w_h_ext >= (w_gun_ext - HALF_W)) && (w_h_ext < (w_gun_ext + HALF_W));
    assign w_in_y  = (i_v_pos >= SHIP_Y0) && (i_v_pos < SHIP_Y1);

    // Registered pixel colour, drawn even while the game is paused.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_color <= COLOR_BG;
        end else if (w_in_x && w_in_y) begin
            r_color <= COLOR_SHIP;
        end else begin
            r_color <= COLOR_BG;
        end
    end

    assign o_gun_position = r_gun;
    assign o_fire         = r_fire;
    assign o_color_ship   = r_color;

endmodule

// File: tb/tb_ship_gun.sv
// Self-checking bench for ship_gun (DEBOUNCE_CYCLES shortened to 4).
// A frame-level model predicts gun position, fire pulses and colour every
// cycle; literal checks pin key positions and shot counts.
module tb_ship_gun;

    localparam int DB    = 4;
    localparam int HALF  = 30;
    localparam int GMIN  = 30;
    localparam int GMAX  = 610;
    localparam int STEPM = 2;
    localparam int COOL  = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       btn_left, btn_right, btn_fire;
    logic       laser;
    logic [9:0] h_pos, v_pos;
    logic [9:0] gun;
    logic       fire;
    logic [2:0] color;

    always #5 clk = ~clk;

    ship_gun #(.DEBOUNCE_CYCLES(DB)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_btn_left     (btn_left),
        .i_btn_right    (btn_right),
        .i_btn_fire     (btn_fire),
        .i_laser_active (laser),
        .i_h_pos        (h_pos),
        .i_v_pos        (v_pos),
        .o_gun_position (gun),
        .o_fire         (fire),
        .o_color_ship   (color)
    );

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    // A button's debounced level flips once the last DB synchronised samples
    // (raw samples delayed two cycles) all disagree with it.
    int         m_gun = 320;
    logic       m_fire = 1'b0;
    logic [2:0] m_color = 3'd0;
    int         m_cool = 0;      // frames left before the next shot
    logic [2:0] m_deb = 3'b000;  // {fire,right,left}
    logic       m_fire_prev = 1'b0;
    logic [7:0] m_hist [3];
    logic [2:0] m_btn;
    logic       m_tick, m_req, m_go;

    assign m_btn  = {btn_fire, btn_right, btn_left};
    assign m_tick = (h_pos == 10'd0) && (v_pos == 10'd480);
`ifdef SHIP_AUTOFIRE_EN
    assign m_req  = m_deb[2];
`else
    assign m_req  = m_deb[2] && !m_fire_prev;
`endif
    assign m_go   = (m_cool == 0) && m_req && !laser && enable;

    always @(posedge clk) begin
        if (reset) begin
            m_gun       <= 320;
            m_fire      <= 1'b0;
            m_color     <= 3'd0;
            m_cool      <= 0;
            m_deb       <= 3'b000;
            m_fire_prev <= 1'b0;
            for (int i = 0; i < 3; i++) m_hist[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_hist[i] <= {m_hist[i][6:0], m_btn[i]};
                if (m_hist[i][DB:1] == {DB{~m_deb[i]}}) m_deb[i] <= ~m_deb[i];
            end
            m_fire_prev <= m_deb[2];
            m_fire      <= m_go;
            if (m_go) m_cool <= COOL;
            else if (m_cool > 0 && m_tick && enable) m_cool <= m_cool - 1;
            if (m_tick && enable && m_deb[0] && !m_deb[1])
                m_gun <= (m_gun - STEPM < GMIN) ? GMIN : m_gun - STEPM;
            else if (m_tick && enable && m_deb[1] && !m_deb[0])
                m_gun <= (m_gun + STEPM > GMAX) ? GMAX : m_gun + STEPM;
            m_color <= (int'(h_pos) >= m_gun - HALF && int'(h_pos) < m_gun + HALF &&
                        v_pos >= 10'd440 && v_pos < 10'd470) ? 3'd2 : 3'd0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (gun !== m_gun[9:0]) begin
                errors++;
                $display("FAIL gun t=%0t got=%0d exp=%0d", $time, gun, m_gun);
            end
            checks++;
            if (fire !== m_fire) begin
                errors++;
                $display("FAIL fire t=%0t got=%b exp=%b", $time, fire, m_fire);
            end
            checks++;
            if (color !== m_color) begin
                errors++;
                $display("FAIL color t=%0t got=%0d exp=%0d", $time, color, m_color);
            end
            if (fire === 1'b1) pulses++;
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One short frame: a tick cycle followed by three off-screen cycles.
    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk); h_pos = 10'd0;   v_pos = 10'd480;
            @(negedge clk); h_pos = 10'd100; v_pos = 10'd100;
            cycles(2);
        end
    endtask

    // Clean press long enough to debounce, then a clean release.
    task automatic press();
        btn_fire = 1'b1; cycles(8);
        btn_fire = 1'b0; cycles(8);
    endtask

    task automatic beam(input int h, input int v, input int exp, input string name);
        h_pos = 10'(h); v_pos = 10'(v);
        @(negedge clk);
        check_lit(name, int'(color), exp);
        h_pos = 10'd100; v_pos = 10'd100;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; laser = 1'b0;
        btn_left = 1'b1; btn_right = 1'b1; btn_fire = 1'b1;
        h_pos = 10'd100; v_pos = 10'd100;
        @(negedge clk); chk_en = 1'b1;
        cycles(2);
        reset = 1'b0;
        check_lit("rst_gun", int'(gun), 320);
        check_lit("rst_fire", int'(fire), 0);
        check_lit("rst_color", int'(color), 0);
        // buttons held through reset re-debounce; both directions hold position
        frames(2);
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
        cycles(10);
        check_lit("post_rst_gun", int'(gun), 320);
        check_lit("post_rst_shot", pulses, 1);
        frames(31);

        // colour window around x=320
        beam(290, 440, 2, "col_290_440");
        beam(349, 469, 2, "col_349_469");
        beam(350, 440, 0, "col_350_440");
        beam(290, 470, 0, "col_290_470");
        beam(289, 440, 0, "col_289_440");

        // short glitch on fire never debounces
        btn_fire = 1'b1; cycles(3);
        btn_fire = 1'b0; cycles(10);
        check_lit("glitch", pulses, 1);

        // cooldown
        press();
        check_lit("shot1", pulses, 2);
        frames(10);
        press();
        check_lit("cool_drop", pulses, 2);
        frames(21);
        press();
        check_lit("shot2", pulses, 3);

        // laser busy gating, no replay
        frames(31);
        laser = 1'b1; press();
        laser = 1'b0; cycles(10);
        check_lit("laser_drop", pulses, 3);
        press();
        check_lit("shot3", pulses, 4);
        // reset mid-cooldown returns to READY
        reset = 1'b1; cycles(2); reset = 1'b0;
        press();
        check_lit("shot_after_rst", pulses, 5);

        // right saturation, then both held
        btn_right = 1'b1; cycles(8);
        frames(200);
        check_lit("right_sat", int'(gun), 610);
        btn_left = 1'b1; cycles(8);
        frames(3);
        check_lit("both_hold", int'(gun), 610);

        // left travel to 34 and saturation at 30
        btn_right = 1'b0; cycles(8);
        frames(288);
        check_lit("left_34", int'(gun), 34);
        frames(1);
        check_lit("left_32", int'(gun), 32);
        frames(1);
        check_lit("left_30", int'(gun), 30);
        frames(1);
        check_lit("left_sat", int'(gun), 30);

        // pause freezes movement and fire
        enable = 1'b0;
        btn_left = 1'b0; btn_right = 1'b1; cycles(8);
        frames(3);
        check_lit("pause_gun", int'(gun), 30);
        press();
        check_lit("pause_fire", pulses, 5);
        enable = 1'b1;
        frames(2);
        check_lit("resume_gun", int'(gun), 34);
        btn_right = 1'b0; cycles(4);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
